instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder (memory side) of the instruction-fetch bus driven by the fetch stage: the fetch stage issues req/addr, and this block answers with gnt, then rdata/rvalid/err.
- Backs a word-addressed instruction RAM.
- Returns in-order responses after a fixed, parameterised latency.
- Caps outstanding requests and injects wait states on demand.
- A boot/test load port writes the RAM.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- LATENCY, 1, cycles from accepted request to rvalid (1..4).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..LATENCY+1).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  request accepted this cycle
- instr_addr_i  in  32  fetch byte address
- instr_rdata_o  out  32  returned instruction word
- instr_rvalid_o  out  1  response valid this cycle
- instr_err_o  out  1  response is an error (qualified by rvalid)
- busy_i  in  1  wait-state injection; blocks grant
- load_we_i  in  1  RAM write strobe (load port)
- load_addr_i  in  32  load byte address
- load_wdata_i  in  32  load data

Behaviour:
- Reset values: instr_gnt_o=0 while rstn low; instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0; outstanding count=0; delay line cleared. RAM contents are not reset.
- Grant: instr_gnt_o = instr_req_i & ~busy_i & ~load_we_i & (count < MAX_OUTSTANDING | retire), where retire = instr_rvalid_o this cycle. Combinational; gnt never asserts without req.
- Accept occurs in a cycle where req & gnt are both high. The initiator may change addr only after accept; the responder samples addr only in the accept cycle.
- Address decode:
  - off = addr - BASE_ADDR; idx = off[31:2]; addr[1:0] ignored (always a whole aligned word).
  - err = (addr < BASE_ADDR) | (idx >= MEM_WORDS).
  - On err: rdata=0, no RAM access.
- Read: RAM read combinationally at accept; {valid, err, data} captured into delay-line stage 0 at the accept clock edge.
- Latency: accept in cycle k gives rvalid=1 in cycle k+LATENCY. Exactly one rvalid per accept; responses strictly in order; back-to-back accepts give back-to-back rvalids.
- Outside rvalid cycles, rdata holds 0 and err holds 0.
- Outstanding count: +1 on accept, -1 on retire; both in the same cycle leave it unchanged. Never exceeds MAX_OUTSTANDING or underflows.
- Load port:
  - Write occurs at the clock edge when load_we_i=1 and the load address is in range; out-of-range writes are dropped silently.
  - Load blocks grant that cycle; in-flight responses keep their already-captured data.
  - Load and accept never coincide.
- busy_i only blocks new grants; it does not delay in-flight responses.
- Reset mid-operation: all in-flight responses are discarded and no rvalid appears after reset release until a new accept.
- Protocol: the initiator holds req until gnt. Dropping req before gnt is legal and cancels the request with no response.

Decomposition:
- Package instr_mem_pkg:
  - typedef instr_resp_t {logic valid; logic err; logic [31:0] rdata;}
  - constant WORD_BYTES=4
  - function addr_in_range(addr, base, words) returning the decode.
- Sub-module instr_mem_delay_line: a LATENCY-stage shift register of instr_resp_t with async reset that clears valid/err/rdata. The top keeps the RAM, grant logic, counter and decode.

Test Plan:
- Preload word 0=0x00000013, word 1=0x00a00093 via the load port; req addr 0x0 then 0x4 back-to-back with LATENCY=1. Required: gnt in cycles 0,1; rvalid in cycles 1,2; rdata 0x00000013 then 0x00a00093; err=0.
- LATENCY=3, MAX_OUTSTANDING=2, req held continuously. Required: gnt in cycles 0,1, low in cycle 2, high again in cycle 3 (retire cycle); count never >2.
- req addr BASE_ADDR+4*MEM_WORDS (0x1000). Required: gnt=1; one cycle later rvalid=1, err=1, rdata=0; the next in-range fetch returns err=0.
- busy_i=1 for cycles 0-4 with req held at addr 0x8. Required: gnt=0 in cycles 0-4, gnt=1 in cycle 5, rvalid in cycle 6 with RAM word 2.
- Accept addr 0x8, assert load_we_i to word 2 with 0xdeadbeef in the next cycle. Required: the response returns the old word; a later fetch of 0x8 returns 0xdeadbeef; gnt=0 during the load cycle.
- Accept a request, pull rstn low for 1 cycle before its rvalid. Required: rvalid/err/rdata=0 during and after reset; count=0; the next accept responds normally.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and address decode for the instruction-fetch responder.
package instr_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } instr_resp_t;

  // True when addr falls on a word inside [base, base + words*WORD_BYTES).
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ((off / WORD_BYTES) < words);
  endfunction

endpackage

// File: rtl/instr_mem_delay_line.sv
// Fixed-latency pipe carrying fetch responses from accept to rvalid.
module instr_mem_delay_line
  import instr_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic        in_err,
  input  logic [31:0] in_rdata,
  output logic        out_valid,
  output logic        out_err,
  output logic [31:0] out_rdata
);

  instr_resp_t stage_reg [LATENCY];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= '{valid: in_valid, err: in_err, rdata: in_rdata};
      for (int i = 1; i < LATENCY; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign out_valid = stage_reg[LATENCY-1].valid;
  assign out_err   = stage_reg[LATENCY-1].err;
  assign out_rdata = stage_reg[LATENCY-1].rdata;

endmodule

// File: rtl/instr_mem_responder.sv
// Memory side of the instruction-fetch bus: word RAM with load port, grant
// throttling on outstanding requests, and in-order fixed-latency responses.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  input  logic        busy_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      mem [MEM_WORDS];
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic [31:0]      fetch_off;
  logic [31:0]      load_off;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;
  logic             fetch_in_range;
  logic             load_in_range;
  logic             accept;
  logic             retire;
  logic             slot_free;
  instr_resp_t      resp_in;
  logic             unused_addr_bits;

  assign fetch_off      = instr_addr_i - BASE_ADDR;
  assign load_off       = load_addr_i - BASE_ADDR;
  assign fetch_idx      = fetch_off[IDX_W+1:2];
  assign load_idx       = load_off[IDX_W+1:2];
  assign fetch_in_range = addr_in_range(instr_addr_i, BASE_ADDR, MEM_WORDS);
  assign load_in_range  = addr_in_range(load_addr_i, BASE_ADDR, MEM_WORDS);
  assign unused_addr_bits = ^{fetch_off[31:IDX_W+2], fetch_off[1:0],
                              load_off[31:IDX_W+2], load_off[1:0]};

  // A response retiring this cycle frees its slot in time for a new grant.
  assign retire      = instr_rvalid_o;
  assign slot_free   = (count_reg < CNT_W'(MAX_OUTSTANDING)) | retire;
  assign instr_gnt_o = rstn & instr_req_i & ~busy_i & ~load_we_i & slot_free;
  assign accept      = instr_req_i & instr_gnt_o;

  always_comb begin
    resp_in = '0;
    if (accept) begin
      resp_in.valid = 1'b1;
      if (fetch_in_range) begin
        resp_in.rdata = mem[fetch_idx];
      end else begin
        resp_in.err = 1'b1;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({accept, retire})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // RAM contents survive reset so a loaded program persists across it.
  always_ff @(posedge clk) begin
    if (load_we_i && load_in_range) begin
      mem[load_idx] <= load_wdata_i;
    end
  end

  instr_mem_delay_line #(
    .LATENCY(LATENCY)
  ) u_delay_line (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (resp_in.valid),
    .in_err   (resp_in.err),
    .in_rdata (resp_in.rdata),
    .out_valid(instr_rvalid_o),
    .out_err  (instr_err_o),
    .out_rdata(instr_rdata_o)
  );

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomised scoreboard bench for instr_mem_responder with a queue-based model.
module tb_instr_mem_responder;

  localparam int          MEM_WORDS = 256;
  localparam logic [31:0] BASE      = 32'h0000_0100;
  localparam int          LATENCY   = 3;
  localparam int          MAX_OUT   = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        busy;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_wdata;

  instr_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .BASE_ADDR(BASE),
    .LATENCY(LATENCY),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .instr_req_i(req),
    .instr_gnt_o(gnt),
    .instr_addr_i(addr),
    .instr_rdata_o(rdata),
    .instr_rvalid_o(rvalid),
    .instr_err_o(err),
    .busy_i(busy),
    .load_we_i(load_we),
    .load_addr_i(load_addr),
    .load_wdata_i(load_wdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model_mem [MEM_WORDS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    longint ua = a;
    longint ub = BASE;
    return (ua < ub) || ((ua - ub) / 4 >= MEM_WORDS);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    longint ua = a;
    longint ub = BASE;
    return int'((ua - ub) / 4);
  endfunction

  // Monitor: expected grant from the pending-response queue; responses popped in order.
  always @(negedge clk) begin : monitor
    logic exp_retire;
    logic exp_gnt;
    exp_t e;
    if (!rstn) begin
      check("rst_gnt", gnt, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      q.delete();
    end else begin
      exp_retire = (q.size() > 0) && (q[0].due == cyc);
      exp_gnt = req && !busy && !load_we && ((q.size() < MAX_OUT) || exp_retire);
      check("gnt", gnt, exp_gnt);
      if (rvalid) begin
        if (!exp_retire) begin
          check("unexpected_rvalid", rvalid, 0);
        end else begin
          e = q.pop_front();
          check("resp_err", err, e.err);
          check("resp_rdata", rdata, e.data);
        end
      end else begin
        check("idle_rdata", rdata, 0);
        check("idle_err", err, 0);
        if (exp_retire) begin
          check("missing_rvalid", rvalid, 1);
          void'(q.pop_front());
        end
      end
      if (req && exp_gnt) begin
        e.due = cyc + LATENCY;
        e.err = model_err(addr);
        e.data = e.err ? 32'h0 : model_mem[model_idx(addr)];
        q.push_back(e);
        $display("accept cycle=%0d addr=%h exp_err=%0b exp_data=%h", cyc, addr, e.err, e.data);
      end
      if (load_we && !model_err(load_addr)) begin
        model_mem[model_idx(load_addr)] = load_wdata;
      end
    end
  end

  task automatic idle(input int n);
    req = 1'b0;
    busy = 1'b0;
    load_we = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    req = 1'b0;
    load_we = 1'b1;
    load_addr = a;
    load_wdata = d;
    @(posedge clk);
    #1;
    load_we = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    int n = 0;
    req = 1'b1;
    addr = a;
    forever begin
      @(negedge clk);
      if (gnt || n > 50) break;
      n++;
      @(posedge clk);
      #1;
    end
    check("fetch_grant_wait", (n <= 50), 1);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = BASE;
      1: a = BASE + 4 * MEM_WORDS - 1;
      2: a = BASE + 4 * MEM_WORDS;
      3: a = BASE - 1;
      4: a = $urandom;
      default: a = BASE + $urandom_range(0, 4 * MEM_WORDS - 1);
    endcase
    return a;
  endfunction

  initial begin
    logic granted;
    rstn = 1'b0;
    req = 1'b0;
    busy = 1'b0;
    load_we = 1'b0;
    addr = '0;
    load_addr = '0;
    load_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < MEM_WORDS; i++) begin
      load(BASE + 4 * i, (i == 0) ? 32'h0000_0013 : (i == 1) ? 32'h00a0_0093 : $urandom);
    end
    load(BASE + 4 * MEM_WORDS, 32'hbad0_0001);
    load(BASE - 4, 32'hbad0_0002);
    idle(2);

    fetch(BASE);
    fetch(BASE + 4);
    idle(LATENCY + 1);

    for (int i = 0; i < 4; i++) fetch(BASE + 4 * i);
    idle(LATENCY + 1);

    fetch(BASE + 4 * MEM_WORDS);
    fetch(BASE - 4);
    fetch(BASE + 4 * MEM_WORDS - 1);
    idle(LATENCY + 1);

    busy = 1'b1;
    req = 1'b1;
    addr = BASE + 8;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    busy = 1'b0;
    fetch(BASE + 8);
    idle(LATENCY + 1);

    fetch(BASE + 8);
    load(BASE + 8, 32'hdead_beef);
    idle(LATENCY + 1);
    fetch(BASE + 8);
    idle(LATENCY + 1);

    fetch(BASE + 12);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(LATENCY + 2);
    fetch(BASE + 16);
    idle(LATENCY + 2);

    granted = 1'b0;
    repeat (600) begin
      if (!req || granted || $urandom_range(0, 9) == 0) begin
        req = ($urandom_range(0, 3) != 0);
        addr = pick_addr();
      end
      busy = ($urandom_range(0, 4) == 0);
      load_we = ($urandom_range(0, 7) == 0);
      if (load_we) begin
        load_addr = pick_addr();
        load_wdata = $urandom;
      end
      @(negedge clk);
      granted = req & gnt;
      @(posedge clk);
      #1;
    end
    idle(LATENCY + 4);

    check("drain_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
